// File: rtl/uaz_isa_pkg.sv
// uaz_isa_pkg: shared ISA encodings for the decode stage.
// Revision: 1.0
`default_nettype none

package uaz_isa_pkg;

  localparam logic [2:0] OP_LOAD_IMM  = 3'b000;
  localparam logic [2:0] OP_LOAD_IND  = 3'b001;
  localparam logic [2:0] OP_STORE_IMM = 3'b010;
  localparam logic [2:0] OP_STORE_IND = 3'b011;
  localparam logic [2:0] OP_MOVE      = 3'b100;
  localparam logic [2:0] OP_MATH      = 3'b101;
  localparam logic [2:0] OP_JUMP      = 3'b110;
  localparam logic [2:0] OP_SYS       = 3'b111;

  // PREFIX is OP_SYS with every rx bit equal to this value, at any REG_AW.
  localparam logic PREFIX_RX_BIT = 1'b1;

  localparam logic [1:0] SEL_PC_SEQ  = 2'b00;
  localparam logic [1:0] SEL_PC_JMP  = 2'b01;
  localparam logic [1:0] SEL_PC_COND = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PFX  = 1'b1
  } dec_state_t;

endpackage

`default_nettype wire

// File: rtl/uaz_decode_logic.sv
// uaz_decode_logic: combinational field decode of one instruction word.
// Revision: 1.0
`default_nettype none

module uaz_decode_logic #(
  parameter  int REG_AW = 3,
  parameter  int N_W    = 8,
  localparam int IW     = 3 + 2 * REG_AW
) (
  input  logic [IW-1:0]     instr,
  input  logic              pfx_valid,
  input  logic [REG_AW-1:0] pfx_arg,
  output logic              move,
  output logic              write,
  output logic              math,
  output logic              sel_out,
  output logic [REG_AW-1:0] j,
  output logic [REG_AW-1:0] k,
  output logic [REG_AW-1:0] i,
  output logic [REG_AW-1:0] f,
  output logic [N_W-1:0]    n,
  output logic [1:0]        sel_pc,
  output logic              is_prefix,
  output logic              uses_prefix
);
  import uaz_isa_pkg::*;

  localparam logic [REG_AW-1:0] JMP_UNCOND_MAX = REG_AW'(1);

  logic [2:0]        opcode;
  logic [REG_AW-1:0] rx;
  logic [REG_AW-1:0] arg;
  logic [N_W-1:0]    imm;

  assign opcode = instr[2:0];
  assign rx     = instr[REG_AW+2:3];
  assign arg    = instr[IW-1:REG_AW+3];

  always_comb begin
    imm = '0;
    if (pfx_valid) imm[2*REG_AW-1:0] = {pfx_arg, arg};
    else           imm[REG_AW-1:0]   = arg;
  end

  assign uses_prefix = (opcode == OP_LOAD_IMM) || (opcode == OP_STORE_IMM);

  always_comb begin
    move      = 1'b0;
    write     = 1'b0;
    math      = 1'b0;
    sel_out   = 1'b0;
    j         = '0;
    k         = '0;
    i         = '0;
    f         = '0;
    n         = '0;
    sel_pc    = SEL_PC_SEQ;
    is_prefix = 1'b0;
    case (opcode)
      OP_LOAD_IMM:  begin k = rx; j = arg; n = imm; end
      OP_LOAD_IND:  begin k = rx; i = arg; sel_out = 1'b1; end
      OP_STORE_IMM: begin write = 1'b1; k = rx; j = arg; n = imm; end
      OP_STORE_IND: begin write = 1'b1; k = rx; i = arg; end
      OP_MOVE:      begin move = 1'b1; k = rx; i = arg; end
      OP_MATH:      begin math = 1'b1; k = rx; f = arg; end
      OP_JUMP: begin
        k      = rx;
        f      = arg;
        sel_pc = (arg <= JMP_UNCOND_MAX) ? SEL_PC_JMP : SEL_PC_COND;
      end
      default: is_prefix = (rx == {REG_AW{PREFIX_RX_BIT}});
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered decode stage with prefix FSM and valid/ready handshake.
// Revision: 1.0
`default_nettype none

module instr_decode_stage #(
  parameter  int REG_AW = 3,
  parameter  int N_W    = 8,
  parameter  int CNT_W  = 16,
  localparam int IW     = 3 + 2 * REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IW-1:0]     in_instr,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              flush,
  output logic              move,
  output logic              write,
  output logic              math,
  output logic              sel_out,
  output logic [REG_AW-1:0] j,
  output logic [REG_AW-1:0] k,
  output logic [REG_AW-1:0] i,
  output logic [REG_AW-1:0] f,
  output logic [N_W-1:0]    n,
  output logic [1:0]        sel_pc,
  output logic              prefix_drop,
  output logic [CNT_W-1:0]  dec_count
);
  import uaz_isa_pkg::*;

  dec_state_t        state, state_next;
  logic [REG_AW-1:0] pfx_arg;
  logic              accept;

  logic              dec_move, dec_write, dec_math, dec_sel_out;
  logic [REG_AW-1:0] dec_j, dec_k, dec_i, dec_f;
  logic [N_W-1:0]    dec_n;
  logic [1:0]        dec_sel_pc;
  logic              dec_is_prefix, dec_uses_prefix;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  uaz_decode_logic #(
    .REG_AW (REG_AW),
    .N_W    (N_W)
  ) u_decode (
    .instr       (in_instr),
    .pfx_valid   (state == ST_PFX),
    .pfx_arg     (pfx_arg),
    .move        (dec_move),
    .write       (dec_write),
    .math        (dec_math),
    .sel_out     (dec_sel_out),
    .j           (dec_j),
    .k           (dec_k),
    .i           (dec_i),
    .f           (dec_f),
    .n           (dec_n),
    .sel_pc      (dec_sel_pc),
    .is_prefix   (dec_is_prefix),
    .uses_prefix (dec_uses_prefix)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush)       state_next = ST_IDLE;
    else if (accept) state_next = dec_is_prefix ? ST_PFX : ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      move        <= 1'b0;
      write       <= 1'b0;
      math        <= 1'b0;
      sel_out     <= 1'b0;
      j           <= '0;
      k           <= '0;
      i           <= '0;
      f           <= '0;
      n           <= '0;
      sel_pc      <= SEL_PC_SEQ;
      prefix_drop <= 1'b0;
      dec_count   <= '0;
      pfx_arg     <= '0;
    end else begin
      prefix_drop <= 1'b0;
      // A transfer that coincides with flush is discarded, not counted.
      if (out_valid && out_ready && !flush) dec_count <= dec_count + 1'b1;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        if (dec_is_prefix) begin
          out_valid   <= 1'b0;
          pfx_arg     <= in_instr[IW-1:REG_AW+3];
          prefix_drop <= (state == ST_PFX);
        end else begin
          out_valid   <= 1'b1;
          move        <= dec_move;
          write       <= dec_write;
          math        <= dec_math;
          sel_out     <= dec_sel_out;
          j           <= dec_j;
          k           <= dec_k;
          i           <= dec_i;
          f           <= dec_f;
          n           <= dec_n;
          sel_pc      <= dec_sel_pc;
          prefix_drop <= (state == ST_PFX) && !dec_uses_prefix;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: randomized and directed checks against a behavioural decode model.
// Revision: 1.0
`default_nettype none

module tb_instr_decode_stage;
  localparam int REG_AW = 3;
  localparam int N_W    = 8;
  localparam int CNT_W  = 4;
  localparam int IW     = 3 + 2 * REG_AW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [IW-1:0]     in_instr = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              flush = 1'b0;
  logic              move, write, math, sel_out;
  logic [REG_AW-1:0] j, k, i, f;
  logic [N_W-1:0]    n;
  logic [1:0]        sel_pc;
  logic              prefix_drop;
  logic [CNT_W-1:0]  dec_count;
  logic [25:0]       obs_fields;

  int checks = 0;
  int errors = 0;

  // Model state: what the outputs must show after the most recent edge.
  bit          m_valid, m_drop, m_pfx;
  int          m_count, m_pfx_arg;
  logic [25:0] m_fields;

  instr_decode_stage #(.REG_AW(REG_AW), .N_W(N_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .move(move), .write(write), .math(math), .sel_out(sel_out),
    .j(j), .k(k), .i(i), .f(f), .n(n), .sel_pc(sel_pc),
    .prefix_drop(prefix_drop), .dec_count(dec_count)
  );

  assign obs_fields = {move, write, math, sel_out, j, k, i, f, n, sel_pc};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [25:0] golden(input int instr, input bit pfx, input int parg,
                                         output bit is_pfx, output bit uses_pfx);
    int op, rx, arg, imm;
    int mv, wr, ma, so, jj, kk, ii, ff, nn, sp;
    op  = instr % 8;
    rx  = (instr / 8) % 8;
    arg = (instr / 64) % 8;
    imm = pfx ? parg * 8 + arg : arg;
    mv = 0; wr = 0; ma = 0; so = 0; jj = 0; kk = 0; ii = 0; ff = 0; nn = 0; sp = 0;
    is_pfx   = (op == 7) && (rx == 7);
    uses_pfx = (op == 0) || (op == 2);
    case (op)
      0: begin kk = rx; jj = arg; nn = imm; end
      1: begin kk = rx; ii = arg; so = 1; end
      2: begin wr = 1; kk = rx; jj = arg; nn = imm; end
      3: begin wr = 1; kk = rx; ii = arg; end
      4: begin mv = 1; kk = rx; ii = arg; end
      5: begin ma = 1; kk = rx; ff = arg; end
      6: begin kk = rx; ff = arg; sp = (arg < 2) ? 1 : 2; end
      default: ;
    endcase
    return {1'(mv), 1'(wr), 1'(ma), 1'(so), 3'(jj), 3'(kk), 3'(ii), 3'(ff), 8'(nn), 2'(sp)};
  endfunction

  task automatic check_outputs();
    check("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) check("fields", 64'(obs_fields), 64'(m_fields));
    check("prefix_drop", 64'(prefix_drop), 64'(m_drop));
    check("dec_count", 64'(dec_count), 64'(m_count));
  endtask

  task automatic step(input bit v, input int instr, input bit ordy, input bit fl);
    bit          exp_rdy, acc, isp, usp;
    logic [25:0] g;
    @(negedge clk);
    check_outputs();
    in_valid  = v;
    in_instr  = instr[IW-1:0];
    out_ready = ordy;
    flush     = fl;
    #1;
    exp_rdy = !fl && (!m_valid || ordy);
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc = v && exp_rdy;
    g = golden(instr, m_pfx, m_pfx_arg, isp, usp);
    if (m_valid && ordy && !fl) m_count = (m_count + 1) % (1 << CNT_W);
    m_drop = 1'b0;
    if (fl) begin
      m_valid = 1'b0;
      m_pfx   = 1'b0;
    end else if (acc) begin
      if (isp) begin
        m_drop    = m_pfx;
        m_pfx     = 1'b1;
        m_pfx_arg = (instr / 64) % 8;
        m_valid   = 1'b0;
      end else begin
        m_drop   = m_pfx && !usp;
        m_pfx    = 1'b0;
        m_valid  = 1'b1;
        m_fields = g;
      end
    end else if (ordy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_fields", 64'(obs_fields), 64'd0);
    check("rst_prefix_drop", 64'(prefix_drop), 64'd0);
    check("rst_dec_count", 64'(dec_count), 64'd0);
    m_valid = 1'b0; m_drop = 1'b0; m_pfx = 1'b0; m_count = 0; m_pfx_arg = 0; m_fields = '0;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_reset", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int ins;
    #2;
    do_reset();

    // Load R2 #5
    step(1, 'h150, 1, 0);
    step(0, 0, 0, 0);
    check("load_k", 64'(k), 64'd2);
    check("load_j", 64'(j), 64'd5);
    check("load_n", 64'(n), 64'h05);
    step(0, 0, 1, 0);

    // PREFIX 3 then Load R2 #5: extended immediate, no drop
    step(1, 'h0FF, 1, 0);
    step(1, 'h150, 1, 0);
    step(0, 0, 0, 0);
    check("pfx_load_n", 64'(n), 64'h1D);
    check("pfx_load_drop", 64'(prefix_drop), 64'd0);
    step(0, 0, 1, 0);

    // PREFIX then Jump R4 cond: prefix dropped
    step(1, 'h0FF, 1, 0);
    step(1, 'h0A6, 1, 0);
    step(0, 0, 1, 0);
    check("pfx_jump_k", 64'(k), 64'd4);
    check("pfx_jump_f", 64'(f), 64'd2);
    check("pfx_jump_sel_pc", 64'(sel_pc), 64'd2);
    check("pfx_jump_drop", 64'(prefix_drop), 64'd1);
    step(0, 0, 1, 0);

    // Back-pressure for three cycles with input held
    step(1, 'h150, 1, 0);
    for (int c = 0; c < 3; c++) step(1, 'h16A, 0, 0);
    step(1, 'h16A, 1, 0);
    step(0, 0, 1, 0);

    // Flush with a held output, then flush with a held prefix
    step(1, 'h150, 1, 0);
    step(0, 0, 1, 1);
    step(1, 'h0FF, 1, 0);
    step(0, 0, 1, 1);
    step(1, 'h150, 1, 0);
    step(0, 0, 0, 0);
    check("flush_pfx_n", 64'(n), 64'h05);
    step(0, 0, 1, 0);

    // Counter wrap: 17 transfers from reset
    do_reset();
    for (int c = 0; c < 17; c++) step(1, 'h150, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("count_wrap", 64'(dec_count), 64'd1);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) ins = int'($urandom_range(0, 7) << 6) | 'h3F;
      else                           ins = int'($urandom_range(0, 511));
      step($urandom_range(0, 3) != 0, ins, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end

    // Reset asserted mid-handshake with a held output
    step(1, 'h150, 1, 0);
    step(1, 'h16A, 0, 0);
    #2;
    do_reset();
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 Parameter REG_AW, default 3, register-address and field width; instruction width IW = 3 + 2*REG_AW.
REQ-002 Parameter N_W, default 8, immediate output width; N_W SHALL be at least 2*REG_AW.
REQ-003 Parameter CNT_W, default 16, width of the decoded-instruction counter.
REQ-004 Clocking SHALL be one clock with an asynchronous, active-low reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 in_instr  in  IW  instruction word: [2:0] opcode, [REG_AW+2:3] rx, [IW-1:REG_AW+3] arg.
REQ-008 in_valid / in_ready  in / out  1  upstream handshake; transfer when both are high at a clock edge.
REQ-009 out_valid / out_ready  out / in  1  downstream handshake.
REQ-010 flush  in  1  synchronous discard of held output and prefix state.
REQ-011 move, write, math, sel_out  out  1 each  registered control bits.
REQ-012 j, k, i, f  out  REG_AW each  registered field selects.
REQ-013 n  out  N_W  registered extended immediate.
REQ-014 sel_pc  out  2  registered: 00 sequential, 01 unconditional jump, 10 conditional jump.
REQ-015 prefix_drop  out  1  one-cycle pulse when a held prefix is discarded unused.
REQ-016 dec_count  out  CNT_W  count of instructions presented on the output.

Function
REQ-017 Opcode 000 Load RX #imm SHALL give k=rx, j=arg, n=imm; other controls 0.
REQ-018 Opcode 001 Load RX [RY] SHALL give k=rx, i=arg, sel_out=1.
REQ-019 Opcode 010 Store RX #imm SHALL give write=1, k=rx, j=arg, n=imm.
REQ-020 Opcode 011 Store RX [RY] SHALL give write=1, k=rx, i=arg.
REQ-021 Opcode 100 Move SHALL give move=1, k=rx, i=arg.
REQ-022 Opcode 101 Math SHALL give math=1, k=rx, f=arg.
REQ-023 Opcode 110 Jump SHALL give k=rx, f=arg (condition is preserved, never zeroed); sel_pc=01 for arg 0..1, otherwise 10.
REQ-024 Opcode 111 with rx != all-ones is NOP: all outputs 0, still emitted with out_valid.
REQ-025 Opcode 111 with rx = all-ones is PREFIX: consumed, no output, arg latched; FSM moves IDLE->PFX.
REQ-026 imm = zero-extend({prefix arg, arg}) when in PFX, otherwise zero-extend(arg); every unlisted field SHALL be 0.
REQ-027 Any non-PREFIX instruction accepted in PFX returns FSM to IDLE; if its opcode is not 000/010, prefix_drop SHALL pulse on the next cycle.
REQ-028 PREFIX accepted in PFX replaces the held arg, stays in PFX, and pulses prefix_drop.
REQ-029 Latency SHALL be one cycle: an accepted non-PREFIX instruction appears on the outputs with out_valid=1 on the next edge.
REQ-030 in_ready = !flush && (!out_valid || out_ready); full throughput of one instruction per cycle.
REQ-031 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-032 flush SHALL clear out_valid, return FSM to IDLE, suppress prefix_drop; a flushed instruction is not counted.
REQ-033 dec_count SHALL increment once per out_valid && out_ready transfer, wrapping from 2^CNT_W-1 to 0.

Reset
REQ-034 Asserting rst_n low SHALL immediately zero all outputs, including out_valid, prefix_drop and dec_count, and set FSM to IDLE, including mid-handshake.
REQ-035 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-036 Opcode constants, PREFIX rx code, sel_pc encodings and FSM state type SHALL live in the shared package uaz_isa_pkg.
REQ-037 Field decode SHALL be one combinational sub-module, uaz_decode_logic; this block owns the registers, FSM and handshake.

Verification
REQ-038 in_instr=0x150 (Load R2 #5) -> next cycle k=2, j=5, n=0x05, out_valid=1, others 0.
REQ-039 Sequence 0x0FF (PREFIX arg 3) then 0x150 -> one output only, n=0x1D, prefix_drop never 1.
REQ-040 Sequence 0x0FF then 0x0A6 (Jump R4, Z-true) -> k=4, f=2, sel_pc=10, prefix_drop pulse one cycle later.
REQ-041 out_ready=0 for 3 cycles with in_valid high -> outputs frozen, in_ready=0, then resumes with no loss or duplication.
REQ-042 flush asserted with out_valid=1 and PFX held -> out_valid=0, FSM IDLE, dec_count unchanged.
REQ-043 CNT_W=4, 17 transfers -> dec_count wraps to 1; rst_n pulsed mid-transfer -> all outputs 0 immediately.
